// File: rtl/vpu_sram_pkg.sv
// Shared sizing, requester indexing and bank-owner encoding for the VPU SRAM responder.
package vpu_sram_pkg;

  localparam int SRAM_READ_PORT_CNT  = 3;
  localparam int SRAM_BANK_CNT       = 4;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH     = 1024;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;
  localparam int SRAM_DATA_WIDTH     = 512;

  localparam int READ_LATENCY = 2;

  // Requesters 0..P-1 are read ports, requester P is the write port.
  localparam int REQ_CNT = SRAM_READ_PORT_CNT + 1;
  localparam int REQ_W   = $clog2(REQ_CNT);
  localparam int WR_REQ  = SRAM_READ_PORT_CNT;

  typedef logic [REQ_W-1:0] req_idx_t;

  typedef struct packed {
    logic     locked;
    req_idx_t who;
  } owner_t;

  localparam owner_t OWNER_FREE = '{locked: 1'b0, who: '0};

  function automatic req_idx_t next_ptr(input req_idx_t r);
    return (r == req_idx_t'(REQ_CNT - 1)) ? '0 : r + 1'b1;
  endfunction

endpackage

// File: rtl/vpu_sram_bank.sv
// Single-port synchronous SRAM bank with a registered read port.
// Writes land at the clock edge; reads return one cycle after the enable.
module vpu_sram_bank
  import vpu_sram_pkg::*;
#(
  parameter int DEPTH = SRAM_BANK_DEPTH,
  parameter int AW    = SRAM_BANK_DEPTH_LG2,
  parameter int W     = SRAM_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vpu_sram_responder.sv
// Banked SRAM responder: per-bank round-robin lock arbitration for P read ports and one
// write port, burst execution against the owning requester, 2-cycle fixed read latency.
module vpu_sram_responder
  import vpu_sram_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [SRAM_READ_PORT_CNT-1:0]                    rreq_i,
  input  logic [SRAM_READ_PORT_CNT*SRAM_BANK_CNT_LG2-1:0]   rid_i,
  input  logic [SRAM_READ_PORT_CNT*SRAM_BANK_DEPTH_LG2-1:0] raddr_i,
  input  logic [SRAM_READ_PORT_CNT-1:0]                    reb_i,
  input  logic [SRAM_READ_PORT_CNT-1:0]                    rlast_i,
  output logic [SRAM_READ_PORT_CNT-1:0]                    rack_o,
  output logic [SRAM_READ_PORT_CNT*SRAM_DATA_WIDTH-1:0]     rdata_o,
  output logic [SRAM_READ_PORT_CNT-1:0]                    rvalid_o,
  input  logic                                             wreq_i,
  input  logic [SRAM_BANK_CNT_LG2-1:0]                     wid_i,
  input  logic [SRAM_BANK_DEPTH_LG2-1:0]                   waddr_i,
  input  logic                                             web_i,
  input  logic                                             wlast_i,
  input  logic [SRAM_DATA_WIDTH-1:0]                       wdata_i,
  output logic                                             wack_o
);

  localparam int P  = SRAM_READ_PORT_CNT;
  localparam int BL = SRAM_BANK_CNT_LG2;
  localparam int AW = SRAM_BANK_DEPTH_LG2;
  localparam int W  = SRAM_DATA_WIDTH;
  localparam int NB = SRAM_BANK_CNT;

  // Unified per-requester view of the read ports and the write port.
  logic [REQ_CNT-1:0] req;
  logic [REQ_CNT-1:0] beat;
  logic [REQ_CNT-1:0] last;
  logic [BL-1:0]      id   [REQ_CNT];
  logic [AW-1:0]      addr [REQ_CNT];

  always_comb begin
    for (int r = 0; r < P; r++) begin
      req[r]  = rreq_i[r];
      beat[r] = reb_i[r];
      last[r] = rlast_i[r];
      id[r]   = rid_i[r*BL +: BL];
      addr[r] = raddr_i[r*AW +: AW];
    end
    req[WR_REQ]  = wreq_i;
    beat[WR_REQ] = web_i;
    last[WR_REQ] = wlast_i;
    id[WR_REQ]   = wid_i;
    addr[WR_REQ] = waddr_i;
  end

  owner_t   owner [NB];
  req_idx_t ptr   [NB];

  logic [REQ_CNT-1:0] held;
  logic [BL-1:0]      held_bank [P];

  always_comb begin
    held = '0;
    for (int r = 0; r < P; r++) begin
      held_bank[r] = '0;
    end
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < REQ_CNT; r++) begin
        if (owner[b].locked && owner[b].who == req_idx_t'(r)) begin
          held[r] = 1'b1;
          if (r < P) begin
            held_bank[r] = BL'(b);
          end
        end
      end
    end
  end

  // Round-robin pick per free bank, scanning from the pointer; lock holders are excluded.
  logic [NB-1:0] grant_vld;
  req_idx_t      grant_who [NB];
  logic [NB-1:0] release_bank;

  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NB; b++) begin
      grant_vld[b] = 1'b0;
      grant_who[b] = '0;
      if (!owner[b].locked) begin
        for (int k = 0; k < REQ_CNT; k++) begin
          idx = (int'(ptr[b]) + k) % REQ_CNT;
          if (!grant_vld[b] && req[idx] && id[idx] == BL'(b) && !held[idx]) begin
            grant_vld[b] = 1'b1;
            grant_who[b] = req_idx_t'(idx);
          end
        end
      end
      release_bank[b] = owner[b].locked && beat[owner[b].who] && last[owner[b].who];
    end
  end

  logic [REQ_CNT-1:0] ack_nxt;
  logic [REQ_CNT-1:0] ack_q;

  always_comb begin
    ack_nxt = '0;
    for (int b = 0; b < NB; b++) begin
      if (grant_vld[b]) begin
        ack_nxt[grant_who[b]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= '0;
      for (int b = 0; b < NB; b++) begin
        owner[b] <= OWNER_FREE;
        ptr[b]   <= '0;
      end
    end else begin
      ack_q <= ack_nxt;
      for (int b = 0; b < NB; b++) begin
        if (grant_vld[b]) begin
          owner[b] <= '{locked: 1'b1, who: grant_who[b]};
          ptr[b]   <= next_ptr(grant_who[b]);
        end else if (release_bank[b]) begin
          owner[b] <= OWNER_FREE;
        end
      end
    end
  end

  assign rack_o = ack_q[P-1:0];
  assign wack_o = ack_q[WR_REQ];

  logic [NB-1:0] bank_en;
  logic [NB-1:0] bank_we;
  logic [AW-1:0] bank_addr  [NB];
  logic [W-1:0]  bank_rdata [NB];

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_en[b]   = 1'b0;
      bank_we[b]   = 1'b0;
      bank_addr[b] = '0;
      if (owner[b].locked) begin
        bank_en[b]   = beat[owner[b].who];
        bank_we[b]   = (owner[b].who == req_idx_t'(WR_REQ));
        bank_addr[b] = addr[owner[b].who];
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    vpu_sram_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (bank_en[b]),
      .we    (bank_we[b]),
      .addr  (bank_addr[b]),
      .wdata (wdata_i),
      .rdata (bank_rdata[b])
    );
  end

  // Stage 1 remembers which bank each beat went to, since the lock may be gone by stage 2.
  logic [P-1:0]  s1_vld;
  logic [BL-1:0] s1_bank [P];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
      for (int p = 0; p < P; p++) begin
        s1_bank[p] <= '0;
      end
    end else begin
      for (int p = 0; p < P; p++) begin
        s1_vld[p]   <= held[p] && reb_i[p];
        s1_bank[p]  <= held_bank[p];
        rvalid_o[p] <= s1_vld[p];
        if (s1_vld[p]) begin
          rdata_o[p*W +: W] <= bank_rdata[s1_bank[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_vpu_sram_responder.sv
// Directed scoreboard bench: stimulus pushes expected acks/read data, a negedge monitor checks them.
module tb_vpu_sram_responder;
  import vpu_sram_pkg::*;

  localparam int P  = SRAM_READ_PORT_CNT;
  localparam int W  = SRAM_DATA_WIDTH;
  localparam int BL = SRAM_BANK_CNT_LG2;
  localparam int AW = SRAM_BANK_DEPTH_LG2;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   rreq, reb, rlast, rack, rvalid;
  logic [P*BL-1:0] rid;
  logic [P*AW-1:0] raddr;
  logic [P*W-1:0] rdata;
  logic           wreq, web, wlast, wack;
  logic [BL-1:0]  wid;
  logic [AW-1:0]  waddr;
  logic [W-1:0]   wdata;

  vpu_sram_responder dut (
    .clk(clk), .rst(rst),
    .rreq_i(rreq), .rid_i(rid), .raddr_i(raddr), .reb_i(reb), .rlast_i(rlast),
    .rack_o(rack), .rdata_o(rdata), .rvalid_o(rvalid),
    .wreq_i(wreq), .wid_i(wid), .waddr_i(waddr), .web_i(web), .wlast_i(wlast),
    .wdata_i(wdata), .wack_o(wack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int           cyc;
    logic         chk;
    logic [W-1:0] d;
  } rd_exp_t;

  int      ack_q [P+1][$];
  rd_exp_t rd_q  [P][$];

  localparam logic [W-1:0] D_A5 = {64{8'hA5}};
  localparam logic [W-1:0] D_3C = {64{8'h3C}};
  localparam logic [W-1:0] D_77 = {64{8'h77}};
  localparam logic [W-1:0] D_11 = {64{8'h11}};
  localparam logic [W-1:0] D_33 = {64{8'h33}};

  always @(negedge clk) begin : mon
    logic [P:0] acks;
    rd_exp_t    e;
    acks = {wack, rack};
    for (int p = 0; p <= P; p++) begin
      while (ack_q[p].size() > 0 && ack_q[p][0] < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL ack%0d_missing: got none, expected ack at cycle %0d", p, ack_q[p][0]);
        void'(ack_q[p].pop_front());
      end
      if (acks[p]) begin
        n_chk++;
        if (ack_q[p].size() == 0 || ack_q[p][0] != cyc) begin
          n_fail++;
          $display("FAIL ack%0d_unexpected: got ack at cycle %0d, expected %0d", p, cyc,
                   (ack_q[p].size() == 0) ? -1 : ack_q[p][0]);
        end else begin
          void'(ack_q[p].pop_front());
        end
      end
    end
    for (int p = 0; p < P; p++) begin
      while (rd_q[p].size() > 0 && rd_q[p][0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL rvalid%0d_missing: got none, expected rvalid at cycle %0d", p, rd_q[p][0].cyc);
        void'(rd_q[p].pop_front());
      end
      if (rvalid[p]) begin
        n_chk++;
        if (rd_q[p].size() == 0 || rd_q[p][0].cyc != cyc) begin
          n_fail++;
          $display("FAIL rvalid%0d_unexpected: got rvalid at cycle %0d, expected %0d", p, cyc,
                   (rd_q[p].size() == 0) ? -1 : rd_q[p][0].cyc);
        end else begin
          e = rd_q[p].pop_front();
          if (e.chk && rdata[p*W +: W] !== e.d) begin
            n_fail++;
            $display("FAIL rdata%0d: got %0h expected %0h", p, rdata[p*W +: W], e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_ack(input int r, input int c);
    ack_q[r].push_back(c);
  endtask

  task automatic exp_rd(input int p, input int c, input logic chk_d, input logic [W-1:0] d);
    rd_exp_t e;
    e.cyc = c; e.chk = chk_d; e.d = d;
    rd_q[p].push_back(e);
  endtask

  task automatic clr_beats();
    reb = '0; rlast = '0; web = 1'b0; wlast = 1'b0;
  endtask

  task automatic clr_all();
    clr_beats();
    rreq = '0; rid = '0; raddr = '0; wreq = 1'b0; wid = '0; waddr = '0; wdata = '0;
  endtask

  task automatic rd_beat(input int p, input int a, input logic l);
    reb[p] = 1'b1;
    raddr[p*AW +: AW] = AW'(a);
    rlast[p] = l;
  endtask

  task automatic do_reset();
    clr_all();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rack", 32'(rack), 0);
    chk("rst_wack", 32'(wack), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata_or", 32'(|rdata), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-beat write burst; leaves the bank free in the cycle after return.
  task automatic wr_one(input int b, input int a, input logic [W-1:0] d);
    wreq = 1'b1; wid = BL'(b); exp_ack(P, cyc + 1);
    tick();
    wreq = 1'b0; web = 1'b1; wlast = 1'b1; waddr = AW'(a); wdata = d;
    tick();
    clr_beats();
  endtask

  int c;

  initial begin
    rst = 1'b1;
    clr_all();
    do_reset();

    // Write then read on bank 1
    wreq = 1'b1; wid = 2'd1; exp_ack(P, cyc + 1);
    tick();
    wreq = 1'b0; web = 1'b1; waddr = 10'd5; wdata = D_A5;
    tick();
    waddr = 10'd6; wdata = D_3C; wlast = 1'b1;
    tick();
    clr_beats();
    rreq[0] = 1'b1; rid[1:0] = 2'd1; exp_ack(0, cyc + 1);
    tick();
    rreq[0] = 1'b0; rd_beat(0, 5, 1'b0); exp_rd(0, cyc + 2, 1'b1, D_A5);
    tick();
    rd_beat(0, 6, 1'b1); exp_rd(0, cyc + 2, 1'b1, D_3C);
    tick();
    clr_beats();
    repeat (3) tick();

    // Contention on bank 2 straight after reset
    do_reset();
    rreq = '1; rid = {2'd2, 2'd2, 2'd2}; wreq = 1'b1; wid = 2'd2;
    c = cyc;
    exp_ack(0, c + 1); exp_ack(1, c + 3); exp_ack(2, c + 5); exp_ack(P, c + 7);
    for (int k = 0; k < P; k++) begin
      tick();
      rreq[k] = 1'b0; rd_beat(k, 0, 1'b1); exp_rd(k, cyc + 2, 1'b0, '0);
      tick();
      clr_beats();
    end
    tick();
    wreq = 1'b0; web = 1'b1; wlast = 1'b1; waddr = 10'd9; wdata = D_77;
    tick();
    clr_beats();
    rreq[0] = 1'b1; rid[1:0] = 2'd2; exp_ack(0, cyc + 1);
    tick();
    rreq[0] = 1'b0; rd_beat(0, 9, 1'b1); exp_rd(0, cyc + 2, 1'b1, D_77);
    tick();
    clr_beats();
    repeat (3) tick();

    // Parallel grants on banks 0/1/3
    wr_one(0, 0, D_11);
    wr_one(3, 0, D_33);
    rreq = '1; rid = {2'd3, 2'd1, 2'd0};
    exp_ack(0, cyc + 1); exp_ack(1, cyc + 1); exp_ack(2, cyc + 1);
    tick();
    rreq = '0;
    rd_beat(0, 0, 1'b0); rd_beat(1, 5, 1'b0); rd_beat(2, 0, 1'b0);
    exp_rd(0, cyc + 2, 1'b1, D_11); exp_rd(1, cyc + 2, 1'b1, D_A5); exp_rd(2, cyc + 2, 1'b1, D_33);
    tick();
    rd_beat(0, 0, 1'b1); rd_beat(1, 6, 1'b1); rd_beat(2, 0, 1'b1);
    exp_rd(0, cyc + 2, 1'b1, D_11); exp_rd(1, cyc + 2, 1'b1, D_3C); exp_rd(2, cyc + 2, 1'b1, D_33);
    tick();
    clr_beats();
    repeat (3) tick();

    // Illegal beats: unlocked reb, req while holding, last without enable
    rreq[0] = 1'b1; rid[1:0] = 2'd1; reb[1] = 1'b1; raddr[2*AW-1:AW] = 10'd5;
    exp_ack(0, cyc + 1);
    tick();
    rid[1:0] = 2'd3; rlast[0] = 1'b1;
    tick();
    rlast[0] = 1'b0; reb[1] = 1'b0;
    rd_beat(0, 5, 1'b0); exp_rd(0, cyc + 2, 1'b1, D_A5);
    tick();
    rreq[0] = 1'b0; rd_beat(0, 6, 1'b1); exp_rd(0, cyc + 2, 1'b1, D_3C);
    tick();
    clr_beats();
    repeat (3) tick();

    // Reset one cycle after two reads are in flight
    rreq[0] = 1'b1; rid[1:0] = 2'd0; rreq[2] = 1'b1; rid[5:4] = 2'd1;
    exp_ack(0, cyc + 1); exp_ack(2, cyc + 1);
    tick();
    rreq = '0; rd_beat(0, 0, 1'b0); rd_beat(2, 5, 1'b0);
    tick();
    do_reset();
    rreq[1] = 1'b1; rid[3:2] = 2'd0; wreq = 1'b1; wid = 2'd1;
    exp_ack(1, cyc + 1); exp_ack(P, cyc + 1);
    tick();
    rreq = '0; wreq = 1'b0;
    rd_beat(1, 0, 1'b1); exp_rd(1, cyc + 2, 1'b1, D_11);
    web = 1'b1; wlast = 1'b1; waddr = 10'd7; wdata = D_77;
    tick();
    clr_beats();
    repeat (4) tick();

    for (int p = 0; p <= P; p++) begin
      chk($sformatf("ack%0d_leftover", p), 32'(ack_q[p].size()), 0);
    end
    for (int p = 0; p < P; p++) begin
      chk($sformatf("rd%0d_leftover", p), 32'(rd_q[p].size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
